mem_port_arbiter: RTL

Arbitrates the single unified instruction/data memory port between the multicycle core's control path (fetch, load, store) and a debug/program-loader requester. Each access goes through a request/grant handshake. The arbiter drives the synchronous memory and returns read data with a valid strobe. CPU has fixed priority, bounded by a starvation counter that guarantees the debug port forward progress.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between the CPU
// control path and a debug/program-loader requester.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata CPU grant pulse, read-valid pulse, read data
//   dbg_*                          same set for the debug requester
//   mem_en/we/addr/wdata           memory command (registered)
//   mem_rdata                      memory read data, one cycle after a read
//
// CPU has fixed priority on ties; a starvation counter forces a debug win
// after STARVE_LIM consecutive CPU wins over a pending debug request.
module mem_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   starve_cnt, starve_nxt;
    logic               owner_dbg, owner_nxt;
    logic               dbg_win;
    logic               mem_en_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic               cpu_gnt_nxt, dbg_gnt_nxt;
    logic               cpu_rvalid_nxt, dbg_rvalid_nxt;

    // Read data goes straight through; qualified by the matching rvalid.
    assign cpu_rdata = mem_rdata;
    assign dbg_rdata = mem_rdata;

    // Next-state, arbitration and next registered outputs.
    always_comb begin
        state_nxt      = state;
        starve_nxt     = starve_cnt;
        owner_nxt      = owner_dbg;
        dbg_win        = 1'b0;
        mem_en_nxt     = 1'b0;
        mem_we_nxt     = mem_we;
        addr_nxt       = mem_addr;
        wdata_nxt      = mem_wdata;
        cpu_gnt_nxt    = 1'b0;
        dbg_gnt_nxt    = 1'b0;
        cpu_rvalid_nxt = 1'b0;
        dbg_rvalid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    dbg_win     = dbg_req && (!cpu_req || (starve_cnt == CNT_MAX));
                    owner_nxt   = dbg_win;
                    mem_en_nxt  = 1'b1;
                    mem_we_nxt  = dbg_win ? dbg_we    : cpu_we;
                    addr_nxt    = dbg_win ? dbg_addr  : cpu_addr;
                    wdata_nxt   = dbg_win ? dbg_wdata : cpu_wdata;
                    cpu_gnt_nxt = !dbg_win;
                    dbg_gnt_nxt = dbg_win;
                    state_nxt   = ACCESS;
                end
                // Counts only CPU wins that overtook a waiting debug request.
                if (!dbg_req || dbg_win) begin
                    starve_nxt = '0;
                end else if (starve_cnt != CNT_MAX) begin
                    starve_nxt = starve_cnt + CNT_W'(1);
                end
            end
            ACCESS: begin
                if (mem_we) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt      = RESP;
                    cpu_rvalid_nxt = !owner_dbg;
                    dbg_rvalid_nxt = owner_dbg;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            owner_dbg  <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            owner_dbg  <= owner_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            cpu_gnt    <= cpu_gnt_nxt;
            dbg_gnt    <= dbg_gnt_nxt;
            cpu_rvalid <= cpu_rvalid_nxt;
            dbg_rvalid <= dbg_rvalid_nxt;
        end
    end

endmodule
